tile_frame_renderer: RTL
========================

// Module: tile_frame_renderer
// PURPOSE
//  Parametrised row/lane tile renderer feeding the VGA adapter. On draw_go it snapshots
//  N_ROWS lane codes plus a scroll offset. For each row it erases last frame's tile
//  (stored internally), then draws the new tile, one pixel per cycle.
//  Sits between the game FSM and the VGA pixel port; replaces per-row draw/erase instances.
// PARAMETERS
//  N_ROWS       6    tile rows rendered per frame (1..15)
//  LANES        4    lanes per row; lane code >= LANES means row empty
//  LANE_W       3    width of one lane code
//  TILE_W       80   tile width, pixels
//  TILE_H       40   tile height/row pitch, pixels; offset must be < TILE_H
//  X0           0    x of lane 0 left edge
//  SCREEN_H     240  pixels with y >= SCREEN_H are clipped
//  OFF_W        6    offset width
//  TILE_COLOR   3'b000  tile fill;  BG_COLOR 3'b111 erase colour;  BORDER_COLOR 3'b100
// PORTS
//  clock        in   1                 system clock, rising edge
//  reset        in   1                 asynchronous, active-high
//  draw_go      in   1                 start frame; sampled only in IDLE
//  row_lanes    in   N_ROWS*LANE_W     row r code at [r*LANE_W +: LANE_W], row 0 = top
//  offset       in   OFF_W             vertical scroll added to every row's y
//  busy         out  1                 high from frame start until done
//  done         out  1                 one-cycle pulse at frame end
//  vga_en       out  1                 pixel write strobe for x/y/color this cycle
//  x            out  9                 pixel x
//  y            out  8                 pixel y
//  color        out  3                 pixel colour
// BEHAVIOUR
//  - Reset: busy=0, done=0, vga_en=0, x=0, y=0, color=0, FSM=IDLE, row=0, dx=dy=0.
//    Stored previous lanes all = LANES (empty); stored previous offset = 0.
//  - Geometry: tile x = X0 + lane*TILE_W + dx, y = r*TILE_H + offset + dy.
//    dx counts 0..TILE_W-1 (inner); dy counts 0..TILE_H-1 (outer). Math is 10-bit, then truncated.
//  - States: IDLE -> LATCH -> ERASE -> DRAW -> NEXT -> (ERASE of row+1 | DONE) -> IDLE.
//  - IDLE: draw_go=1 -> LATCH. busy rises the cycle after draw_go is sampled.
//  - LATCH (1 cycle): cur_lanes<=row_lanes, cur_off<=offset; row=0. Inputs ignored until IDLE.
//  - ERASE: if prev lane of row is empty, skip to DRAW immediately (0 pixel cycles).
//    Else emit TILE_W*TILE_H pixels at prev lane/prev offset, color=BG_COLOR.
//  - DRAW: same, using cur lane/cur offset, color=TILE_COLOR; empty row -> skip.
//  - NEXT (1 cycle): row++; after row N_ROWS-1 -> DONE.
//  - DONE (1 cycle): done=1; prev lanes<=cur_lanes; prev offset<=cur_off; -> IDLE, busy=0.
//  - Pixels are registered: x/y/color/vga_en are valid the same cycle. Clipped pixels
//    (y >= SCREEN_H) still take a cycle with vga_en=0. x/y/color hold when vga_en=0.
//  - Whole-row erase precedes draw, so row r's new tile overwrites row r-1 erase overlap.
//    Erase of row r+1 may clip row r's new tile where they overlap; accepted artefact.
//  - draw_go held high: a new frame starts on the cycle after DONE (back-to-back frames).
//  - Reset mid-frame: immediate return to reset state. History is cleared, so the next
//    frame erases nothing.
//  - Frame length = 2 + N_ROWS + (nonempty prev rows + nonempty cur rows)*TILE_W*TILE_H cycles.
// CONFIGURATION
//  TILE_BORDER_EN defined: in DRAW, pixels with dx==0, dx==TILE_W-1, dy==0 or
//    dy==TILE_H-1 use BORDER_COLOR; interior pixels use TILE_COLOR.
//  TILE_BORDER_EN undefined: every DRAW pixel uses TILE_COLOR; BORDER_COLOR unused.
//  ERASE timing, frame length and all other behaviour are identical in both builds.
// TESTING (defaults, TILE_BORDER_EN off unless stated)
//  1 After reset: row_lanes all 3'd4, offset 0, draw_go pulse -> no vga_en.
//    done pulses 2+6=8 cycles after LATCH entry.
//  2 After reset: row0=2, others empty, offset 0 -> 3200 writes, x 160..239, y 0..39,
//    color 000, first write (160,0), last (239,39); done follows.
//  3 Then row0=1, offset 5 -> 3200 erases at x 160..239 y 0..39 colour 111,
//    then 3200 draws at x 80..159 y 5..44.
//  4 row5=0, offset 20 -> rows y 220..239 written; 20*80=1600 cycles with vga_en=0
//    for y 240..259; no write has y >= 240.
//  5 Reset asserted mid-DRAW -> outputs 0 at once. Next frame with the same lanes
//    produces draws only (no erase).
//  6 TILE_BORDER_EN on, case 2 -> (160,0) and (239,39) are 100; (161,1) is 000.
//    Total cycle count matches the border-off build.

Source files
------------

// File: rtl/tile_frame_renderer.sv
// -----------------------------------------------------------------------------
// tile_frame_renderer
//
// Row/lane tile renderer that drives a VGA adapter's pixel-write port.
// A frame starts when draw_go is sampled in IDLE. The renderer snapshots one
// lane code per row together with a vertical scroll offset. It then walks the
// rows top to bottom. For each row it first erases the tile drawn in the
// previous frame, using the stored lane and offset. It then draws the new tile.
// Each pixel takes one clock cycle.
//
// Optional build macro:
//   TILE_BORDER_EN  - when defined, DRAW pixels on the tile's outer ring use
//                     BORDER_COLOR and interior pixels use TILE_COLOR. When it
//                     is undefined, every DRAW pixel uses TILE_COLOR. Timing is
//                     identical in both builds.
//
// Ports:
//   clock      in   rising-edge system clock
//   reset      in   asynchronous, active-high reset
//   draw_go    in   start a frame (sampled only while idle)
//   row_lanes  in   row r lane code at [r*LANE_W +: LANE_W], row 0 = top;
//                   a code >= LANES marks the row as empty
//   offset     in   vertical scroll added to every row's y
//   busy       out  high from the cycle after draw_go is sampled until frame end
//   done       out  one-cycle pulse when a frame has completed
//   vga_en     out  pixel write strobe qualifying x/y/color
//   x, y       out  pixel coordinate
//   color      out  pixel colour
// -----------------------------------------------------------------------------
module tile_frame_renderer #(
    parameter int          N_ROWS       = 6,
    parameter int          LANES        = 4,
    parameter int          LANE_W       = 3,
    parameter int          TILE_W       = 80,
    parameter int          TILE_H       = 40,
    parameter int          X0           = 0,
    parameter int          SCREEN_H     = 240,
    parameter int          OFF_W        = 6,
    parameter logic [2:0]  TILE_COLOR   = 3'b000,
    parameter logic [2:0]  BG_COLOR     = 3'b111,
    parameter logic [2:0]  BORDER_COLOR = 3'b100
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       draw_go,
    input  logic [N_ROWS*LANE_W-1:0]   row_lanes,
    input  logic [OFF_W-1:0]           offset,
    output logic                       busy,
    output logic                       done,
    output logic                       vga_en,
    output logic [8:0]                 x,
    output logic [7:0]                 y,
    output logic [2:0]                 color
);

    localparam int RW  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int DXW = (TILE_W > 1) ? $clog2(TILE_W) : 1;
    localparam int DYW = (TILE_H > 1) ? $clog2(TILE_H) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_ERASE,
        S_DRAW,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                      state_reg;
    logic [RW-1:0]               row_reg;
    logic [DXW-1:0]              dx_reg;
    logic [DYW-1:0]              dy_reg;
    logic [N_ROWS*LANE_W-1:0]    cur_lanes_reg;
    logic [OFF_W-1:0]            cur_off_reg;
    logic [N_ROWS*LANE_W-1:0]    prev_lanes_reg;
    logic [OFF_W-1:0]            prev_off_reg;

    // Per-row views of the latched and stored lane codes.
    logic [LANE_W-1:0]           cur_lane  [N_ROWS];
    logic [LANE_W-1:0]           prev_lane [N_ROWS];
    logic [N_ROWS-1:0]           cur_empty;
    logic [N_ROWS-1:0]           prev_empty;

    genvar gi;
    generate
        for (gi = 0; gi < N_ROWS; gi++) begin : g_row
            assign cur_lane[gi]   = cur_lanes_reg[gi*LANE_W +: LANE_W];
            assign prev_lane[gi]  = prev_lanes_reg[gi*LANE_W +: LANE_W];
            assign cur_empty[gi]  = (32'(cur_lane[gi])  >= LANES);
            assign prev_empty[gi] = (32'(prev_lane[gi]) >= LANES);
        end
    endgenerate

    // While in LATCH the row-0 entry decision must use the live input, because
    // cur_lanes_reg is only loaded at the end of that cycle.
    logic in_row0_empty;
    assign in_row0_empty = (32'(row_lanes[LANE_W-1:0]) >= LANES);

    // Pixel address datapath. ERASE uses the previous frame's lane and offset.
    // DRAW uses the current frame's lane and offset.
    logic [LANE_W-1:0] sel_lane;
    logic [OFF_W-1:0]  sel_off;
    logic [9:0]        px;
    logic [9:0]        py;
    logic              on_screen;
    logic              dx_last;
    logic              dy_last;
    logic              tile_end;
    logic              row_last;
    logic [RW-1:0]     row_inc;
    logic [2:0]        draw_color;

    always_comb begin
        sel_lane = cur_lane[row_reg];
        sel_off  = cur_off_reg;
        if (state_reg == S_ERASE) begin
            sel_lane = prev_lane[row_reg];
            sel_off  = prev_off_reg;
        end
    end

    assign px        = 10'(X0) + 10'(sel_lane) * 10'(TILE_W) + 10'(dx_reg);
    assign py        = 10'(row_reg) * 10'(TILE_H) + 10'(sel_off) + 10'(dy_reg);
    assign on_screen = (py < 10'(SCREEN_H));
    assign dx_last   = (dx_reg == DXW'(TILE_W - 1));
    assign dy_last   = (dy_reg == DYW'(TILE_H - 1));
    assign tile_end  = dx_last && dy_last;
    assign row_last  = (row_reg == RW'(N_ROWS - 1));
    assign row_inc   = row_reg + 1'b1;

`ifdef TILE_BORDER_EN
    logic on_border;
    assign on_border  = (dx_reg == '0) || dx_last || (dy_reg == '0) || dy_last;
    assign draw_color = on_border ? BORDER_COLOR : TILE_COLOR;
`else
    assign draw_color = TILE_COLOR;
`endif

    // First state used for a row. An empty erase or draw phase costs no
    // cycles, so this decision jumps straight past the phases that are skipped.
    function automatic state_t row_entry(input logic p_empty, input logic c_empty);
        if (!p_empty) begin
            return S_ERASE;
        end else if (!c_empty) begin
            return S_DRAW;
        end else begin
            return S_NEXT;
        end
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            row_reg        <= '0;
            dx_reg         <= '0;
            dy_reg         <= '0;
            cur_lanes_reg  <= {N_ROWS{LANE_W'(LANES)}};
            cur_off_reg    <= '0;
            prev_lanes_reg <= {N_ROWS{LANE_W'(LANES)}};
            prev_off_reg   <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            vga_en         <= 1'b0;
            x              <= '0;
            y              <= '0;
            color          <= '0;
        end else begin
            done   <= 1'b0;
            vga_en <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (draw_go) begin
                        state_reg <= S_LATCH;
                        busy      <= 1'b1;
                    end
                end

                S_LATCH: begin
                    cur_lanes_reg <= row_lanes;
                    cur_off_reg   <= offset;
                    row_reg       <= '0;
                    dx_reg        <= '0;
                    dy_reg        <= '0;
                    state_reg     <= row_entry(prev_empty[0], in_row0_empty);
                end

                S_ERASE, S_DRAW: begin
                    // Clipped pixels still take their cycle. x/y/color hold.
                    vga_en <= on_screen;
                    if (on_screen) begin
                        x     <= 9'(px);
                        y     <= 8'(py);
                        color <= (state_reg == S_ERASE) ? BG_COLOR : draw_color;
                    end
                    // dx is the inner counter and dy is the outer counter.
                    if (dx_last) begin
                        dx_reg <= '0;
                        if (dy_last) begin
                            dy_reg <= '0;
                        end else begin
                            dy_reg <= dy_reg + 1'b1;
                        end
                    end else begin
                        dx_reg <= dx_reg + 1'b1;
                    end
                    if (tile_end) begin
                        if (state_reg == S_ERASE && !cur_empty[row_reg]) begin
                            state_reg <= S_DRAW;
                        end else begin
                            state_reg <= S_NEXT;
                        end
                    end
                end

                S_NEXT: begin
                    if (row_last) begin
                        state_reg <= S_DONE;
                    end else begin
                        row_reg   <= row_inc;
                        state_reg <= row_entry(prev_empty[row_inc], cur_empty[row_inc]);
                    end
                end

                S_DONE: begin
                    done           <= 1'b1;
                    busy           <= 1'b0;
                    prev_lanes_reg <= cur_lanes_reg;
                    prev_off_reg   <= cur_off_reg;
                    state_reg      <= S_IDLE;
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule
